mux_rr_arbiter: RTL

- Round-robin arbiter that shares one 4:1 mux datapath (four 1-bit inputs, 2-bit select) between four requesters.
- Samples per-requester request lines, grants exactly one owner, and drives the mux select to that owner's input.
- Caps ownership at HOLD_MAX cycles so no requester can starve the others.
- Sits directly in front of the mux select input; the grant vector goes back to the requesters.

---
 rtl/mux_rr_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select line of a shared 4:1 mux.
// A grant lasts at most HOLD_MAX cycles; re-arbitration happens without idle gaps.
module mux_rr_arbiter #(
    parameter int HOLD_W   = 3,
    parameter int HOLD_MAX = 4
) (
    input  logic       clock,
    input  logic       reset_b,
    input  logic [3:0] req,
    output logic [1:0] select,
    output logic [3:0] grant,
    output logic       busy,
    output logic       grant_change
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t              state_reg;
    logic [1:0]          last_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [1:0]          select_reg;
    logic [3:0]          grant_reg;
    logic                busy_reg;
    logic                grant_change_reg;

    logic [1:0]          cand_idx [4];
    logic [3:0]          cand_req;
    logic [1:0]          win_next;
    logic                any_req;
    logic                keep_owner;

    // Candidate k is last+1+k, so the current owner is always examined last.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_scan
            assign cand_idx[gi] = last_reg + 2'(gi + 1);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_next = last_reg;
        for (int k = 3; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_next = cand_idx[k];
            end
        end
    end

    assign any_req    = |req;
    assign keep_owner = (state_reg == GRANT) && req[last_reg] &&
                        (hold_cnt_reg < HOLD_W'(HOLD_MAX));

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state_reg        <= IDLE;
            last_reg         <= 2'd3;
            hold_cnt_reg     <= '0;
            select_reg       <= 2'd0;
            grant_reg        <= 4'd0;
            busy_reg         <= 1'b0;
            grant_change_reg <= 1'b0;
        end else begin
            grant_change_reg <= 1'b0;
            if (keep_owner) begin
                hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
            end else if (any_req) begin
                // Fresh grant, possibly to the same owner after its hold expired.
                state_reg        <= GRANT;
                last_reg         <= win_next;
                hold_cnt_reg     <= HOLD_W'(1);
                select_reg       <= win_next;
                grant_reg        <= 4'b0001 << win_next;
                busy_reg         <= 1'b1;
                grant_change_reg <= 1'b1;
            end else begin
                state_reg <= IDLE;
                grant_reg <= 4'd0;
                busy_reg  <= 1'b0;
            end
        end
    end

    assign select       = select_reg;
    assign grant        = grant_reg;
    assign busy         = busy_reg;
    assign grant_change = grant_change_reg;

endmodule
